mv_select: RTL and testbench
============================

Name: mv_select

Overview:
- Result-side counterpart of the search controller. It consumes the same `ctr_word`/`en_pe` control stream that drives the PE array, together with the SAD values the array returns.
- It attributes each SAD to a candidate (row, column) and tracks the minimum across one full search window.
- At window end it emits the winning motion vector and its SAD. It sits between the PE array output and the downstream motion-vector store.

Parameters:
- `SAD_WIDTH`, 16, width of SAD values (16x16 block of 8-bit pixels).
- `PE_LATENCY`, 2, cycles from `ctr_word`/`en_pe` issue to matching `sad_in`; legal range 1..8.
- `NUM_ROWS`, 16, candidate rows per search window; legal range 1..16.
- `ROW_WIDTH`, 4, width of the row index; must satisfy 2^`ROW_WIDTH` >= `NUM_ROWS`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ctr_word`  in  4  control word from the search controller.
- `en_pe`  in  1  PE enable from the search controller.
- `sad_in`  in  `SAD_WIDTH`  SAD from the PE array, valid `PE_LATENCY` cycles after its control word.
- `mv_row`  out  `ROW_WIDTH`  winning candidate row.
- `mv_col`  out  4  winning candidate column (0..13).
- `best_sad`  out  `SAD_WIDTH`  winning SAD.
- `mv_valid`  out  1  one-cycle pulse; `mv_row`/`mv_col`/`best_sad` valid.
- `overrun`  out  1  one-cycle pulse; a window was aborted by a new start marker.
- `busy`  out  1  high while in SEARCH.

Behaviour:
- **Reset:** asynchronous, active-low; all state cleared. Outputs at reset: `mv_row`=0, `mv_col`=0, `best_sad`=0, `mv_valid`=0, `overrun`=0, `busy`=0. State=IDLE, delay line cleared. Reset asserted mid-window discards the window with no output pulse.
- **Delay line:** `en_pe` and `ctr_word` registered through `PE_LATENCY` stages, giving `d_en` and `d_word`. All decoding below uses the delayed pair in the same cycle `sad_in` is sampled.
- **Decode:**
  - Start marker = `d_en` && `d_word`==4'hf.
  - Candidate strobe = `d_en` && `d_word` in 1..14; column = `d_word`-1.
  - Row end = candidate strobe with `d_word`==4'he.
  - `d_en` with `d_word`==0 is ignored.
  - Any `d_word` activity while `d_en`=0 is ignored.
- **Registers:** `row_cnt` (`ROW_WIDTH`), `cur_min` (`SAD_WIDTH`), `cur_row`, `cur_col`, `first` flag.
- **State IDLE:**
  - Start marker -> SEARCH: `row_cnt`=0, `first`=1.
  - Candidate strobes in IDLE are ignored.
- **State SEARCH** (`busy`=1):
  - Candidate strobe: if `first` or `sad_in` < `cur_min` (strict, unsigned), load `cur_min`=`sad_in`, `cur_row`=`row_cnt`, `cur_col`=column, and clear `first`. Ties keep the earlier candidate.
  - Row end with `row_cnt` != `NUM_ROWS`-1: increment `row_cnt`.
  - Row end with `row_cnt`==`NUM_ROWS`-1: the comparison on that final candidate is included. Next state DONE.
  - Start marker in SEARCH: pulse `overrun` for 1 cycle, discard the window, restart (`row_cnt`=0, `first`=1), stay in SEARCH.
- **State DONE** (1 cycle):
  - Register `mv_row`/`mv_col`/`best_sad` from the `cur_*` values; `mv_valid`=1 in the cycle after DONE is entered.
  - Outputs hold their values until the next `mv_valid`.
  - Start marker coincident with DONE: result still emitted; next state SEARCH with a fresh window (no `overrun`). Otherwise next state IDLE.
- **Latency:** `mv_valid` rises 2 cycles after the final candidate's `sad_in` sample.
- **Arithmetic:** comparison only, no accumulation; no wrap possible. `row_cnt` never exceeds `NUM_ROWS`-1.
- **Regular cycle compatibility:** the controller's 24-cycle slot issues `ctr_word` 1..e on consecutive cycles with `en_pe`=1, then 4'hf at the next slot start.
  - Each slot is therefore one candidate row.
  - The 4'hf at a slot start after the window's final row acts as the next window's start marker.
  - 4'hf at slot starts during a window would abort it. The controller gates window starts so only one 4'hf precedes each `NUM_ROWS`-row window; mid-window slots start with `ctr_word`=0 and `en_pe`=1.

Test Plan:
- Reset, then start marker and 16 rows of 14 SADs, all 1000 except (row 5, col 9)=17. Required: one `mv_valid` pulse 2 cycles after last sample with `mv_row`=5, `mv_col`=9, `best_sad`=17; `busy` falls.
- Ties: all SADs 300 except (2,3)=100 and (7,1)=100. Required: `mv_row`=2, `mv_col`=3, `best_sad`=100.
- Latency sweep, `PE_LATENCY`=1 and 8, minimum at (0,0)=0 and at (15,13)=0 in separate runs. Required: correct vector each run; a SAD offset by one cycle from the expected slot must not be selected.
- Abort: start marker after row 3, then a full window with min (1,1)=42. Required: `overrun` pulses once; only one `mv_valid` with (1,1,42).
- Back-to-back windows, next start marker coincident with DONE. Required: two `mv_valid` pulses with respective vectors, `overrun` never asserted.
- Reset mid-window (`rst_n` low at row 8, asynchronous between edges). Required: all outputs 0 immediately, no `mv_valid`; the next full window reports correctly.

Source files
------------

// File: rtl/mv_select.sv
// mv_select: attributes PE-array SADs to search candidates and reports
// the minimum-SAD motion vector at the end of each search window.
module mv_select #(
  parameter int SAD_WIDTH  = 16,
  parameter int PE_LATENCY = 2,
  parameter int NUM_ROWS   = 16,
  parameter int ROW_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           ctr_word,
  input  logic                 en_pe,
  input  logic [SAD_WIDTH-1:0] sad_in,
  output logic [ROW_WIDTH-1:0] mv_row,
  output logic [3:0]           mv_col,
  output logic [SAD_WIDTH-1:0] best_sad,
  output logic                 mv_valid,
  output logic                 overrun,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [PE_LATENCY-1:0]      en_q;
  logic [PE_LATENCY-1:0][3:0] word_q;
  logic                       d_en;
  logic [3:0]                 d_word;

  logic                 start, cand, row_end, last_row;
  logic [3:0]           col;
  logic [ROW_WIDTH-1:0] row_cnt, cur_row;
  logic [3:0]           cur_col;
  logic [SAD_WIDTH-1:0] cur_min;
  logic                 first;

  // Align the control stream with the PE array's result latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= '0;
      word_q <= '0;
    end else begin
      en_q[0]   <= en_pe;
      word_q[0] <= ctr_word;
      for (int i = 1; i < PE_LATENCY; i++) begin
        en_q[i]   <= en_q[i-1];
        word_q[i] <= word_q[i-1];
      end
    end
  end

  assign d_en     = en_q[PE_LATENCY-1];
  assign d_word   = word_q[PE_LATENCY-1];
  assign start    = d_en && (d_word == 4'hf);
  assign cand     = d_en && (d_word != 4'h0) && (d_word != 4'hf);
  assign row_end  = cand && (d_word == 4'he);
  assign col      = d_word - 4'd1;
  assign last_row = (row_cnt == ROW_WIDTH'(NUM_ROWS - 1));
  assign busy     = (state == SEARCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = SEARCH;
      SEARCH: begin
        unique case (1'b1)
          start:               state_nx = SEARCH;
          row_end && last_row: state_nx = DONE;
          default:             state_nx = SEARCH;
        endcase
      end
      DONE:    state_nx = start ? SEARCH : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      cur_row <= '0;
      cur_col <= '0;
      cur_min <= '0;
      first   <= 1'b0;
    end else if (start) begin
      row_cnt <= '0;
      first   <= 1'b1;
    end else if (state == SEARCH && cand) begin
      // Strict compare: ties keep the earlier candidate
      if (first || sad_in < cur_min) begin
        cur_min <= sad_in;
        cur_row <= row_cnt;
        cur_col <= col;
        first   <= 1'b0;
      end
      if (row_end && !last_row) row_cnt <= row_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_row   <= '0;
      mv_col   <= '0;
      best_sad <= '0;
      mv_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun  <= (state == SEARCH) && start;
      mv_valid <= (state == DONE);
      if (state == DONE) begin
        mv_row   <= cur_row;
        mv_col   <= cur_col;
        best_sad <= cur_min;
      end
    end
  end

endmodule

// File: tb/tb_mv_select.sv
// tb_mv_select: drives three mv_select instances (latency 2, 1, 8)
// from one control stream with a modelled PE array and a scoreboard.
module tb_mv_select;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  ctr_word = '0;
  logic        en_pe = 1'b0;
  logic [15:0] cur_val = '0;
  logic [15:0] pipe [8];
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe[0] <= cur_val;
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
  end

  logic [2:0][3:0]  mv_row, mv_col;
  logic [2:0][15:0] best_sad;
  logic [2:0]       mv_valid, overrun, busy;

  mv_select #(.PE_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .ctr_word(ctr_word), .en_pe(en_pe),
    .sad_in(pipe[1]), .mv_row(mv_row[0]), .mv_col(mv_col[0]),
    .best_sad(best_sad[0]), .mv_valid(mv_valid[0]),
    .overrun(overrun[0]), .busy(busy[0]));

  mv_select #(.PE_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .ctr_word(ctr_word), .en_pe(en_pe),
    .sad_in(pipe[0]), .mv_row(mv_row[1]), .mv_col(mv_col[1]),
    .best_sad(best_sad[1]), .mv_valid(mv_valid[1]),
    .overrun(overrun[1]), .busy(busy[1]));

  mv_select #(.PE_LATENCY(8)) u_l8 (
    .clk(clk), .rst_n(rst_n), .ctr_word(ctr_word), .en_pe(en_pe),
    .sad_in(pipe[7]), .mv_row(mv_row[2]), .mv_col(mv_col[2]),
    .best_sad(best_sad[2]), .mv_valid(mv_valid[2]),
    .overrun(overrun[2]), .busy(busy[2]));

  typedef struct {
    int row; int col; int sad; int cyc;
  } exp_t;

  typedef struct {
    int base;
    int r1; int c1; int v1;
    int r2; int c2; int v2;
    int er; int ec; int es;
  } vec_t;

  exp_t        q0[$], q1[$], q2[$];
  logic [15:0] grid [16][14];
  int          tests = 0;
  int          fails = 0;
  int          ovr_cnt [3] = '{0, 0, 0};
  int          exp_row, exp_col, exp_sad;
  vec_t        vt [6];

  function automatic int lat(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 8;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic mon_pop(input int k);
    exp_t e;
    bit   got;
    got = 1'b0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
    endcase
    if (!got) begin
      chk($sformatf("unexpected_mv_valid[L%0d]", lat(k)), 1, 0);
    end else begin
      chk($sformatf("mv_row[L%0d]", lat(k)), int'(mv_row[k]), e.row);
      chk($sformatf("mv_col[L%0d]", lat(k)), int'(mv_col[k]), e.col);
      chk($sformatf("best_sad[L%0d]", lat(k)), int'(best_sad[k]), e.sad);
      chk($sformatf("latency[L%0d]", lat(k)), cyc, e.cyc + lat(k) + 2);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n && mv_valid[k]) mon_pop(k);
      if (rst_n && overrun[k]) ovr_cnt[k]++;
    end
  end

  task automatic push_exp();
    exp_t e;
    e.row = exp_row; e.col = exp_col; e.sad = exp_sad; e.cyc = cyc;
    q0.push_back(e);
    q1.push_back(e);
    q2.push_back(e);
  endtask

  task automatic step(input logic [3:0] w, input logic e,
                      input logic [15:0] v);
    ctr_word = w;
    en_pe    = e;
    cur_val  = v;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'h0, 1'b0, 16'd0);
  endtask

  task automatic fill(input int base);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 14; c++) grid[r][c] = 16'(base);
  endtask

  // Gap cycles between rows carry en_pe=1, word 0 and a decoy SAD of 0
  task automatic window(input bit start, input int rows, input bit push);
    if (start) step(4'hf, 1'b1, 16'd0);
    for (int r = 0; r < rows; r++) begin
      if (r > 0) step(4'h0, 1'b1, 16'd0);
      for (int c = 0; c < 14; c++) begin
        if (push && r == rows - 1 && c == 13) push_exp();
        step(4'(c + 1), 1'b1, grid[r][c]);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_row"}, int'(mv_row[k]), 0);
      chk({tag, "_col"}, int'(mv_col[k]), 0);
      chk({tag, "_sad"}, int'(best_sad[k]), 0);
      chk({tag, "_valid"}, int'(mv_valid[k]), 0);
      chk({tag, "_overrun"}, int'(overrun[k]), 0);
      chk({tag, "_busy"}, int'(busy[k]), 0);
    end
  endtask

  initial begin
    vt[0] = '{1000,  5,  9,    17,  5,  9,    17,  5,  9,    17};
    vt[1] = '{300,   2,  3,   100,  7,  1,   100,  2,  3,   100};
    vt[2] = '{500,   0,  0,     0,  0,  0,     0,  0,  0,     0};
    vt[3] = '{500,  15, 13,     0, 15, 13,     0, 15, 13,     0};
    vt[4] = '{65535, 9,  0, 65534,  3, 13, 65535,  9,  0, 65534};
    vt[5] = '{200,   4,  4,   199,  4,  5,   198,  4,  5,   198};

    repeat (12) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(4);
    chk_zero("post_reset");

    for (int i = 0; i < 6; i++) begin
      fill(vt[i].base);
      grid[vt[i].r1][vt[i].c1] = 16'(vt[i].v1);
      grid[vt[i].r2][vt[i].c2] = 16'(vt[i].v2);
      exp_row = vt[i].er; exp_col = vt[i].ec; exp_sad = vt[i].es;
      window(1'b1, 16, 1'b1);
      idle(20);
      chk($sformatf("busy_idle_v%0d", i), int'(busy), 0);
    end

    // Abort: partial window with smaller SADs, then a fresh full window
    fill(10);
    window(1'b1, 4, 1'b0);
    chk("busy_partial", int'(busy[0]), 1);
    fill(1000);
    grid[1][1] = 16'd42;
    exp_row = 1; exp_col = 1; exp_sad = 42;
    window(1'b1, 16, 1'b1);
    idle(20);
    for (int k = 0; k < 3; k++)
      chk($sformatf("overrun_abort[L%0d]", lat(k)), ovr_cnt[k], 1);

    // Back-to-back: second start marker lands on the DONE cycle
    fill(800);
    grid[3][7] = 16'd5;
    exp_row = 3; exp_col = 7; exp_sad = 5;
    window(1'b1, 16, 1'b1);
    fill(900);
    grid[12][2] = 16'd8;
    exp_row = 12; exp_col = 2; exp_sad = 8;
    window(1'b1, 16, 1'b1);
    idle(20);
    for (int k = 0; k < 3; k++)
      chk($sformatf("overrun_b2b[L%0d]", lat(k)), ovr_cnt[k], 1);

    // Asynchronous reset in the middle of a window
    fill(1000);
    grid[5][9] = 16'd17;
    window(1'b1, 8, 1'b0);
    chk("busy_mid", int'(busy), 3'b111);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    idle(3);
    rst_n = 1'b1;
    idle(12);
    fill(700);
    grid[6][12] = 16'd33;
    exp_row = 6; exp_col = 12; exp_sad = 33;
    window(1'b1, 16, 1'b1);
    idle(20);

    chk("q_empty_L2", q0.size(), 0);
    chk("q_empty_L1", q1.size(), 0);
    chk("q_empty_L8", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
